// File: rtl/triangle_setup_if.sv
// Triangle setup bus: projector-side triangle input plus rasterizer-side setup result.
interface triangle_setup_if #(
  parameter int unsigned COORD_WIDTH = 32
);
  logic                                    tri_valid;
  logic signed [2:0][2:0][COORD_WIDTH-1:0] tri_verts;
  logic                                    tri_ready;
  logic                                    setup_valid;
  logic                                    setup_ready;
  logic [15:0]                             bbox_x_min;
  logic [15:0]                             bbox_x_max;
  logic [15:0]                             bbox_y_min;
  logic [15:0]                             bbox_y_max;
  logic signed [2:0][COORD_WIDTH+1:0]      edge_a;
  logic signed [2:0][COORD_WIDTH+1:0]      edge_b;
  logic signed [2:0][COORD_WIDTH+1:0]      edge_c;
  logic signed [COORD_WIDTH+1:0]           area2;
  logic [2:0][COORD_WIDTH-1:0]             vert_z;
  logic                                    done;
  logic [1:0]                              status;
  logic                                    busy;

  // Driver of triangles and consumer of setup results.
  modport master (
    output tri_valid, tri_verts, setup_ready,
    input  tri_ready, setup_valid, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
           edge_a, edge_b, edge_c, area2, vert_z, done, status, busy
  );

  // The setup stage itself.
  modport slave (
    input  tri_valid, tri_verts, setup_ready,
    output tri_ready, setup_valid, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
           edge_a, edge_b, edge_c, area2, vert_z, done, status, busy
  );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup: integer vertices, clamped bounding box, edge functions and signed area.
// Culls degenerate, off-screen and optionally back-facing triangles.
module triangle_setup #(
  parameter int unsigned COORD_WIDTH   = 32,
  parameter int unsigned FB_WIDTH      = 320,
  parameter int unsigned FB_HEIGHT     = 180,
  parameter int unsigned CULL_BACKFACE = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  triangle_setup_if.slave io_bus
);
  localparam int unsigned W  = COORD_WIDTH;
  localparam int unsigned HW = COORD_WIDTH / 2;
  localparam int unsigned EW = COORD_WIDTH + 2;
  localparam logic signed [HW-1:0] X_MAX = HW'(FB_WIDTH - 1);
  localparam logic signed [HW-1:0] Y_MAX = HW'(FB_HEIGHT - 1);

  typedef enum logic [3:0] {
    StIdle, StConvert, StBbox, StEdge0, StEdge1, StEdge2, StArea, StDecide, StOutput
  } state_e;

  state_e                r_state, w_state_next;
  logic signed [HW-1:0]  r_px [3];
  logic signed [HW-1:0]  r_py [3];
  logic [2:0][W-1:0]     r_z;
  logic [15:0]           r_x_min, r_x_max, r_y_min, r_y_max;
  logic                  r_empty;
  logic signed [EW-1:0]  r_edge_a [3];
  logic signed [EW-1:0]  r_edge_b [3];
  logic signed [EW-1:0]  r_edge_c [3];
  logic signed [EW-1:0]  r_area2;
  logic                  r_done;
  logic [1:0]            r_status;

  logic signed [HW-1:0]  w_px [3];
  logic signed [HW-1:0]  w_py [3];
  logic                  w_unused_frac;
  logic signed [HW-1:0]  w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [1:0]            w_ei, w_ej;
  logic signed [HW-1:0]  w_pxi, w_pyi, w_pxj, w_pyj;
  logic signed [W-1:0]   w_prod_ij, w_prod_ji;
  logic signed [EW-1:0]  w_edge_a, w_edge_b, w_edge_c;
  logic                  w_done_evt;
  logic [1:0]            w_status_next;
  logic                  w_negate;

  function automatic logic [15:0] clamp_coord(input logic signed [HW-1:0] v,
                                              input logic signed [HW-1:0] hi);
    logic signed [HW-1:0] c;
    if (v < 0)       c = '0;
    else if (v > hi) c = hi;
    else             c = v;
    return 16'(c);
  endfunction

  // Integer part of x/y is an arithmetic floor; fractional bits are dropped.
  always_comb begin
    w_unused_frac = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_px[k] = io_bus.tri_verts[k][0][W-1:HW];
      w_py[k] = io_bus.tri_verts[k][1][W-1:HW];
      w_unused_frac = w_unused_frac ^ (^io_bus.tri_verts[k][0][HW-1:0])
                                    ^ (^io_bus.tri_verts[k][1][HW-1:0]);
    end
  end

  // Raw (unclamped) extents of the captured vertices.
  always_comb begin
    w_x_lo = r_px[0];
    w_x_hi = r_px[0];
    w_y_lo = r_py[0];
    w_y_hi = r_py[0];
    for (int k = 1; k < 3; k++) begin
      if (r_px[k] < w_x_lo) w_x_lo = r_px[k];
      if (r_px[k] > w_x_hi) w_x_hi = r_px[k];
      if (r_py[k] < w_y_lo) w_y_lo = r_py[k];
      if (r_py[k] > w_y_hi) w_y_hi = r_py[k];
    end
  end

  // Edge i runs from vertex i to vertex (i+1) mod 3; one multiplier pair shared by all edges.
  always_comb begin
    w_ei = 2'd0;
    w_ej = 2'd1;
    case (r_state)
      StEdge1: begin w_ei = 2'd1; w_ej = 2'd2; end
      StEdge2: begin w_ei = 2'd2; w_ej = 2'd0; end
      default: ;
    endcase
    w_pxi     = r_px[w_ei];
    w_pyi     = r_py[w_ei];
    w_pxj     = r_px[w_ej];
    w_pyj     = r_py[w_ej];
    w_prod_ij = W'(w_pxi) * W'(w_pyj);
    w_prod_ji = W'(w_pxj) * W'(w_pyi);
    w_edge_a  = EW'(w_pyi) - EW'(w_pyj);
    w_edge_b  = EW'(w_pxj) - EW'(w_pxi);
    w_edge_c  = EW'(w_prod_ij) - EW'(w_prod_ji);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state, cull decision and done event.
  always_comb begin
    w_state_next  = r_state;
    w_done_evt    = 1'b0;
    w_status_next = 2'b00;
    w_negate      = 1'b0;
    unique case (r_state)
      StIdle:    if (io_bus.tri_valid) w_state_next = StConvert;
      StConvert: w_state_next = StBbox;
      StBbox:    w_state_next = StEdge0;
      StEdge0:   w_state_next = StEdge1;
      StEdge1:   w_state_next = StEdge2;
      StEdge2:   w_state_next = StArea;
      StArea:    w_state_next = StDecide;
      StDecide: begin
        if (r_area2 == '0) begin
          w_done_evt    = 1'b1;
          w_status_next = 2'b10;
          w_state_next  = StIdle;
        end else if (r_empty) begin
          w_done_evt    = 1'b1;
          w_status_next = 2'b11;
          w_state_next  = StIdle;
        end else if ((r_area2 < 0) && (CULL_BACKFACE != 0)) begin
          w_done_evt    = 1'b1;
          w_status_next = 2'b01;
          w_state_next  = StIdle;
        end else begin
          w_negate     = (r_area2 < 0);
          w_state_next = StOutput;
        end
      end
      StOutput: begin
        if (io_bus.setup_ready) begin
          w_done_evt   = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: capture, bbox, edge coefficients, area and optional orientation flip.
  // Conversion is pure wiring, so px/py/z are captured on acceptance; CONVERT is a latency slot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < 3; k++) begin
        r_px[k]     <= '0;
        r_py[k]     <= '0;
        r_edge_a[k] <= '0;
        r_edge_b[k] <= '0;
        r_edge_c[k] <= '0;
      end
      r_z     <= '0;
      r_x_min <= '0;
      r_x_max <= '0;
      r_y_min <= '0;
      r_y_max <= '0;
      r_empty <= 1'b0;
      r_area2 <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (io_bus.tri_valid) begin
            for (int k = 0; k < 3; k++) begin
              r_px[k]  <= w_px[k];
              r_py[k]  <= w_py[k];
              r_z[k]   <= io_bus.tri_verts[k][2];
            end
          end
        end
        StBbox: begin
          r_x_min <= clamp_coord(w_x_lo, X_MAX);
          r_x_max <= clamp_coord(w_x_hi, X_MAX);
          r_y_min <= clamp_coord(w_y_lo, Y_MAX);
          r_y_max <= clamp_coord(w_y_hi, Y_MAX);
          r_empty <= (w_x_hi < 0) || (w_y_hi < 0) || (w_x_lo > X_MAX) || (w_y_lo > Y_MAX);
        end
        StEdge0, StEdge1, StEdge2: begin
          r_edge_a[w_ei] <= w_edge_a;
          r_edge_b[w_ei] <= w_edge_b;
          r_edge_c[w_ei] <= w_edge_c;
        end
        StArea: r_area2 <= r_edge_c[0] + r_edge_c[1] + r_edge_c[2];
        StDecide: begin
          if (w_negate) begin
            for (int k = 0; k < 3; k++) begin
              r_edge_a[k] <= -r_edge_a[k];
              r_edge_b[k] <= -r_edge_b[k];
              r_edge_c[k] <= -r_edge_c[k];
            end
            r_area2 <= -r_area2;
          end
        end
        default: ;
      endcase
    end
  end

  // One-cycle done pulse with its status; status holds until the next triangle completes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_done   <= 1'b0;
      r_status <= 2'b00;
    end else begin
      r_done <= w_done_evt;
      if (w_done_evt) r_status <= w_status_next;
    end
  end

  assign io_bus.tri_ready   = (r_state == StIdle);
  assign io_bus.busy        = (r_state != StIdle);
  assign io_bus.setup_valid = (r_state == StOutput);
  assign io_bus.bbox_x_min  = r_x_min;
  assign io_bus.bbox_x_max  = r_x_max;
  assign io_bus.bbox_y_min  = r_y_min;
  assign io_bus.bbox_y_max  = r_y_max;
  assign io_bus.area2       = r_area2;
  assign io_bus.vert_z      = r_z;
  assign io_bus.done        = r_done;
  assign io_bus.status      = r_status;

  for (genvar k = 0; k < 3; k++) begin : g_edge_out
    assign io_bus.edge_a[k] = r_edge_a[k];
    assign io_bus.edge_b[k] = r_edge_b[k];
    assign io_bus.edge_c[k] = r_edge_c[k];
  end
endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: one culling instance and one flipping instance side by side.
module tb_triangle_setup;
  localparam int W = 32;
  localparam logic [31:0] Z0 = 32'h0005_0000;
  localparam logic [31:0] Z1 = 32'hFFFE_8000;
  localparam logic [31:0] Z2 = 32'h0007_4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ea [3];
  int   eb [3];
  int   ec [3];

  triangle_setup_if #(.COORD_WIDTH(W)) bus_c ();
  triangle_setup_if #(.COORD_WIDTH(W)) bus_n ();

  triangle_setup #(.COORD_WIDTH(W), .FB_WIDTH(320), .FB_HEIGHT(180), .CULL_BACKFACE(1)) dut_c (
    .clk_in (clk),
    .rst_in (rst),
    .io_bus (bus_c)
  );

  triangle_setup #(.COORD_WIDTH(W), .FB_WIDTH(320), .FB_HEIGHT(180), .CULL_BACKFACE(0)) dut_n (
    .clk_in (clk),
    .rst_in (rst),
    .io_bus (bus_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q(input int v);
    return v << 16;
  endfunction

  task automatic drive_tri(input logic [31:0] x0, y0, x1, y1, x2, y2);
    logic [2:0][2:0][31:0] v;
    v[0][0] = x0; v[0][1] = y0; v[0][2] = Z0;
    v[1][0] = x1; v[1][1] = y1; v[1][2] = Z1;
    v[2][0] = x2; v[2][1] = y2; v[2][2] = Z2;
    bus_c.tri_verts = v;
    bus_n.tri_verts = v;
  endtask

  task automatic set_valid(input logic v);
    bus_c.tri_valid = v;
    bus_n.tri_valid = v;
  endtask

  task automatic set_ready(input logic r);
    bus_c.setup_ready = r;
    bus_n.setup_ready = r;
  endtask

  // Leaves the bench at the falling edge right after the accepting edge.
  task automatic pulse_tri(input logic [31:0] x0, y0, x1, y1, x2, y2);
    @(negedge clk);
    drive_tri(x0, y0, x1, y1, x2, y2);
    set_valid(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
  endtask

  // Cycles after acceptance until the culling instance shows setup_valid or done; -1 on timeout.
  task automatic wait_evt(output int k);
    k = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_c.setup_valid || bus_c.done) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_setup(input string pfx, input bit use_n, input int ar);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_a%0d", pfx, i),
               use_n ? $signed(bus_n.edge_a[i]) : $signed(bus_c.edge_a[i]), ea[i]);
      check_eq($sformatf("%s_b%0d", pfx, i),
               use_n ? $signed(bus_n.edge_b[i]) : $signed(bus_c.edge_b[i]), eb[i]);
      check_eq($sformatf("%s_c%0d", pfx, i),
               use_n ? $signed(bus_n.edge_c[i]) : $signed(bus_c.edge_c[i]), ec[i]);
    end
    check_eq({pfx, "_area2"}, use_n ? bus_n.area2 : bus_c.area2, ar);
  endtask

  task automatic check_bbox(input string pfx, input int x0, x1, y0, y1);
    check_eq({pfx, "_xmin"}, bus_c.bbox_x_min, x0);
    check_eq({pfx, "_xmax"}, bus_c.bbox_x_max, x1);
    check_eq({pfx, "_ymin"}, bus_c.bbox_y_min, y0);
    check_eq({pfx, "_ymax"}, bus_c.bbox_y_max, y1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    set_valid(1'b0);
    set_ready(1'b1);
    drive_tri(q(0), q(0), q(0), q(0), q(0), q(0));

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tri_ready", bus_c.tri_ready, 1);
    check_eq("rst_setup_valid", bus_c.setup_valid, 0);
    check_eq("rst_done", bus_c.done, 0);
    check_eq("rst_busy", bus_c.busy, 0);
    check_eq("rst_status", bus_c.status, 0);
    check_eq("rst_area2", bus_c.area2, 0);
    rst = 1'b0;

    // Basic CCW-in-screen triangle
    pulse_tri(q(10), q(10), q(20), q(10), q(10), q(30));
    wait_evt(k);
    check_eq("t1_latency", k, 7);
    check_eq("t1_valid_c", bus_c.setup_valid, 1);
    check_eq("t1_valid_n", bus_n.setup_valid, 1);
    check_eq("t1_done_early", bus_c.done, 0);
    check_eq("t1_busy", bus_c.busy, 1);
    check_eq("t1_tri_ready", bus_c.tri_ready, 0);
    check_bbox("t1", 10, 20, 10, 30);
    ea = '{0, -20, 20}; eb = '{10, -10, 0}; ec = '{-100, 500, -200};
    check_setup("t1c", 1'b0, 200);
    check_setup("t1n", 1'b1, 200);
    check_eq("t1_z0", bus_c.vert_z[0], Z0);
    check_eq("t1_z1", bus_c.vert_z[1], Z1);
    check_eq("t1_z2", bus_c.vert_z[2], Z2);
    step();
    check_eq("t1_done", bus_c.done, 1);
    check_eq("t1_status", bus_c.status, 0);
    check_eq("t1_valid_after", bus_c.setup_valid, 0);
    check_eq("t1_ready_after", bus_c.tri_ready, 1);
    step();
    check_eq("t1_done_pulse", bus_c.done, 0);

    // Same triangle, reversed winding
    pulse_tri(q(10), q(10), q(10), q(30), q(20), q(10));
    wait_evt(k);
    check_eq("t2_latency", k, 7);
    check_eq("t2_done_c", bus_c.done, 1);
    check_eq("t2_status_c", bus_c.status, 1);
    check_eq("t2_valid_c", bus_c.setup_valid, 0);
    check_eq("t2_valid_n", bus_n.setup_valid, 1);
    ea = '{20, -20, 0}; eb = '{0, -10, 10}; ec = '{-200, 500, -100};
    check_setup("t2n", 1'b1, 200);
    step();
    check_eq("t2_done_n", bus_n.done, 1);
    check_eq("t2_status_n", bus_n.status, 0);
    step();

    // Collinear -> degenerate
    pulse_tri(q(0), q(0), q(10), q(10), q(20), q(20));
    wait_evt(k);
    check_eq("t3_latency", k, 7);
    check_eq("t3_done_c", bus_c.done, 1);
    check_eq("t3_status_c", bus_c.status, 2);
    check_eq("t3_status_n", bus_n.status, 2);
    check_eq("t3_valid_n", bus_n.setup_valid, 0);
    step();

    // Entirely right of the framebuffer -> off-screen
    pulse_tri(q(330), q(10), q(340), q(10), q(330), q(30));
    wait_evt(k);
    check_eq("t4_latency", k, 7);
    check_eq("t4_status_c", bus_c.status, 3);
    check_eq("t4_status_n", bus_n.status, 3);
    check_eq("t4_done_n", bus_n.done, 1);
    step();

    // Straddles both sides horizontally -> clamped bbox
    pulse_tri(q(-5), q(10), q(400), q(10), q(-5), q(30));
    wait_evt(k);
    check_eq("t5_valid", bus_c.setup_valid, 1);
    check_bbox("t5", 0, 319, 10, 30);
    check_eq("t5_area2", bus_c.area2, 8100);
    check_eq("t5_c1", $signed(bus_c.edge_c[1]), 12050);
    step();
    check_eq("t5_done", bus_c.done, 1);
    step();

    // Rasterizer stall: outputs held, new tri_valid pulses ignored
    set_ready(1'b0);
    pulse_tri(q(10), q(10), q(20), q(10), q(10), q(30));
    wait_evt(k);
    check_eq("t6_latency", k, 7);
    for (int c = 0; c < 20; c++) begin
      check_eq("t6_hold_valid", bus_c.setup_valid, 1);
      check_eq("t6_hold_tri_ready", bus_c.tri_ready, 0);
      check_eq("t6_hold_area2", bus_c.area2, 200);
      check_eq("t6_hold_done", bus_c.done, 0);
      drive_tri(q(0), q(0), q(10), q(10), q(20), q(20));
      set_valid((c == 3) || (c == 10));
      step();
    end
    set_valid(1'b0);
    check_eq("t6_c1_held", $signed(bus_c.edge_c[1]), 500);
    set_ready(1'b1);
    step();
    check_eq("t6_done", bus_c.done, 1);
    check_eq("t6_status", bus_c.status, 0);
    check_eq("t6_done_n", bus_n.done, 1);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus_c.done || bus_c.setup_valid) cnt++;
    end
    check_eq("t6_no_extra", cnt, 0);

    // Reset while in EDGE1 drops the triangle
    pulse_tri(q(10), q(10), q(20), q(10), q(10), q(30));
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_eq("t7_tri_ready", bus_c.tri_ready, 1);
    check_eq("t7_valid", bus_c.setup_valid, 0);
    check_eq("t7_done", bus_c.done, 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus_c.done || bus_c.setup_valid || bus_n.done) cnt++;
    end
    check_eq("t7_no_done", cnt, 0);
    pulse_tri(q(10), q(10), q(20), q(10), q(10), q(30));
    wait_evt(k);
    check_eq("t7_fresh_latency", k, 7);
    check_eq("t7_fresh_area2", bus_c.area2, 200);
    step();
    check_eq("t7_fresh_done", bus_c.done, 1);
    step();

    // Fractional vertices floor toward minus infinity
    pulse_tri(32'h000A_C000, 32'h000A_4000, 32'h0014_8000, 32'h000A_E666,
              32'hFFFF_8000, q(30));
    wait_evt(k);
    check_eq("t8_valid", bus_c.setup_valid, 1);
    check_bbox("t8", 0, 20, 10, 30);
    ea = '{0, -20, 20}; eb = '{10, -21, 11}; ec = '{-100, 610, -310};
    check_setup("t8c", 1'b0, 200);
    step();
    check_eq("t8_done", bus_c.done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
